// File: rtl/deser_pkg.sv
// deser_pkg: shared state encoding, default width and frame-length helper for the stream deserializer
package deser_pkg;
  typedef enum logic {COLLECT = 1'b0, SPARE = 1'b1} state_e;
  localparam int DESER_DEFAULT_WIDTH = 8;
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction
endpackage

// File: rtl/deser_bit_counter.sv
// deser_bit_counter: modulo-F bit counter with enable, sync clear and terminal-count flag
module deser_bit_counter #(
  parameter int F  = 8,
  parameter int CW = $clog2(F + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc_o  = cnt_q == CW'(F - 1);
  assign cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + 1'b1) : cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/mux_stream_deserializer.sv
// mux_stream_deserializer: assembles WIDTH-bit words from a qualified serial stream into a valid/ready output register.
// Optional trailing even-parity bit per frame when DESER_PARITY_EN is defined.
module mux_stream_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overflow,
  output logic             parity_err
);
`ifdef DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int F  = frame_len(WIDTH, PAR_EN);
  localparam int CW = $clog2(F + 1);
  state_e           state_q;
  logic [CW-1:0]    cnt;
  logic             tc, data_bit, complete, load;
  logic [WIDTH-1:0] sr_q, sr_d, shifted, word_q;
  logic             valid_q, ovf_q;
  deser_bit_counter #(.F(F), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bit_valid),
    .clr_i (1'b0),
    .cnt_o (cnt),
    .tc_o  (tc)
  );
  // the trailing parity bit is counted but never shifted into the data word
  assign data_bit = PAR_EN ? cnt < CW'(WIDTH) : 1'b1;
  assign shifted  = MSB_FIRST ? {sr_q[WIDTH-2:0], bit_in} : {bit_in, sr_q[WIDTH-1:1]};
  assign sr_d     = (bit_valid && data_bit) ? shifted : sr_q;
  assign complete = bit_valid && tc && state_q == COLLECT;
  assign load     = complete && (!valid_q || word_ready);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= COLLECT;
      sr_q    <= sr_d;
      if (load) begin
        word_q  <= sr_d;
        valid_q <= 1'b1;
      end else if (complete) ovf_q <= 1'b1;
      else if (word_ready) valid_q <= 1'b0;
    end
`ifdef DESER_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk)
    if (!rst_n)    perr_q <= 1'b0;
    else if (load) perr_q <= ^sr_d ^ bit_in;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_mux_stream_deserializer.sv
// tb_mux_stream_deserializer: drives MSB-first and LSB-first instances from one stream against a queue-based reference model
module tb_mux_stream_deserializer;
  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam int F   = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int F   = W;
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, word_ready = 1'b0;
  logic [W-1:0] wo_m, wo_l;
  logic wv_m, wv_l, ov_m, ov_l, pe_m, pe_l;
  int errors = 0, checks = 0;
  bit q[$];
  logic [W-1:0] e_word[2];
  logic e_valid[2], e_ovf[2], e_perr[2];
  always #5 clk = ~clk;
  mux_stream_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .word_ready(word_ready),
    .word_out(wo_m), .word_valid(wv_m), .overflow(ov_m), .parity_err(pe_m));
  mux_stream_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .word_ready(word_ready),
    .word_out(wo_l), .word_valid(wv_l), .overflow(ov_l), .parity_err(pe_l));
  task automatic model_edge();
    logic [W-1:0] wm, wl;
    bit par, done;
    if (!rst_n) begin
      q.delete();
      for (int d = 0; d < 2; d++) begin
        e_word[d] = '0; e_valid[d] = 1'b0; e_ovf[d] = 1'b0; e_perr[d] = 1'b0;
      end
      return;
    end
    done = 1'b0; wm = '0; wl = '0; par = 1'b0;
    if (bit_valid) begin
      q.push_back(bit_in);
      if (q.size() == F) begin
        done = 1'b1;
        for (int i = 0; i < F; i++) par ^= q[i];
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = q[i];
          wl[i]     = q[i];
        end
        q.delete();
      end
    end
    for (int d = 0; d < 2; d++)
      if (done && (!e_valid[d] || word_ready)) begin
        e_word[d]  = d ? wl : wm;
        e_valid[d] = 1'b1;
        e_perr[d]  = PAR ? par : 1'b0;
      end else if (done) e_ovf[d] = 1'b1;
      else if (word_ready) e_valid[d] = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic send_bit(input logic b);
    bit_in = b; bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
  endtask
  task automatic send_word(input logic [W-1:0] v, input logic pbit, input bit gap);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(v[i]);
      if (gap && (i > 0 || PAR)) begin
        bit_in = 1'($urandom);
        step();
      end
    end
    if (PAR) send_bit(pbit);
  endtask
  task automatic test_reset();
    rst_n = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
    step(); step();
    checks++;
    if ({wo_m, wv_m, ov_m, pe_m, wo_l, wv_l, ov_l, pe_l} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got m=%h/%b/%b/%b l=%h/%b/%b/%b want all zero", wo_m, wv_m, ov_m, pe_m, wo_l, wv_l, ov_l, pe_l);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bit_in = 1'($urandom);
      step();
      checks++;
      if ({wv_m, wv_l} !== 2'b00) begin
        errors++;
        $display("FAIL idle_valid cycle %0d: got %b%b want 00", c, wv_m, wv_l);
      end
    end
  endtask
  task automatic test_msb_first();
    word_ready = 1'b1;
    send_word(8'hA5, ^8'hA5, 1'b0);
    checks++;
    if (wo_m !== 8'hA5 || wv_m !== 1'b1) begin
      errors++;
      $display("FAIL msb_a5: got word=%h valid=%b want word=a5 valid=1", wo_m, wv_m);
    end
    step();
    checks++;
    if (wv_m !== 1'b0) begin
      errors++;
      $display("FAIL msb_a5_one_cycle: got valid=%b want 0", wv_m);
    end
  endtask
  task automatic test_lsb_first_gaps();
    word_ready = 1'b1;
    send_word(8'hA5, ^8'hA5, 1'b1);
    checks++;
    if (wo_l !== 8'hA5 || wv_l !== 1'b1 || wo_l !== e_word[1]) begin
      errors++;
      $display("FAIL lsb_a5_gaps: got word=%h valid=%b want word=a5 valid=1", wo_l, wv_l);
    end
    step();
    checks++;
    if ({wv_m, wv_l} !== 2'b00) begin
      errors++;
      $display("FAIL lsb_a5_drain: got %b%b want 00", wv_m, wv_l);
    end
  endtask
  task automatic test_overflow();
    word_ready = 1'b0;
    send_word(8'h3C, ^8'h3C, 1'b0);
    checks++;
    if (wo_m !== 8'h3C || wv_m !== 1'b1 || ov_m !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: got word=%h valid=%b ovf=%b want 3c/1/0", wo_m, wv_m, ov_m);
    end
    send_word(8'hC3, ^8'hC3, 1'b0);
    checks++;
    if (wo_m !== 8'h3C || wv_m !== 1'b1 || ov_m !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got word=%h valid=%b ovf=%b want 3c/1/1", wo_m, wv_m, ov_m);
    end
    checks++;
    if (wo_l !== e_word[1] || ov_l !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop_lsb: got word=%h ovf=%b want %h/1", wo_l, ov_l, e_word[1]);
    end
    word_ready = 1'b1;
    step();
    checks++;
    if (wv_m !== 1'b0 || ov_m !== 1'b1 || wo_m !== 8'h3C) begin
      errors++;
      $display("FAIL ovf_sticky: got valid=%b ovf=%b word=%h want 0/1/3c", wv_m, ov_m, wo_m);
    end
  endtask
  task automatic test_reset_mid_frame();
    word_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    send_word(8'h81, ^8'h81, 1'b0);
    checks++;
    if (wo_m !== 8'h81 || wo_l !== 8'h81 || wv_m !== 1'b1 || ov_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got m=%h l=%h valid=%b ovf=%b want 81/81/1/0", wo_m, wo_l, wv_m, ov_m);
    end
    step();
  endtask
`ifdef DESER_PARITY_EN
  task automatic test_parity();
    word_ready = 1'b1;
    send_word(8'h07, 1'b1, 1'b0);
    checks++;
    if (pe_m !== 1'b0 || wo_m !== 8'h07 || pe_l !== 1'b0) begin
      errors++;
      $display("FAIL parity_ok: got perr=%b/%b word=%h want 0/0/07", pe_m, pe_l, wo_m);
    end
    send_word(8'h07, 1'b0, 1'b0);
    checks++;
    if (pe_m !== 1'b1 || wo_m !== 8'h07 || pe_l !== 1'b1) begin
      errors++;
      $display("FAIL parity_bad: got perr=%b/%b word=%h want 1/1/07", pe_m, pe_l, wo_m);
    end
    step();
  endtask
`endif
  task automatic test_back_to_back();
    logic [W-1:0] v;
    word_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      v = W'($urandom);
      send_word(v, ^v, 1'b0);
      checks++;
      if (wo_m !== v || wv_m !== 1'b1 || ov_m !== 1'b0 || wo_l !== e_word[1]) begin
        errors++;
        $display("FAIL b2b frame %0d: got m=%h l=%h valid=%b ovf=%b want %h/%h/1/0", f, wo_m, wo_l, wv_m, ov_m, v, e_word[1]);
      end
    end
    step();
  endtask
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_n      = $urandom_range(0, 499) != 0;
      bit_valid  = $urandom_range(0, 3) != 0;
      bit_in     = 1'($urandom);
      word_ready = $urandom_range(0, 2) != 0;
      step();
      checks++;
      if ({wo_m, wv_m, ov_m, pe_m, wo_l, wv_l, ov_l, pe_l} !==
          {e_word[0], e_valid[0], e_ovf[0], e_perr[0], e_word[1], e_valid[1], e_ovf[1], e_perr[1]}) begin
        errors++;
        $display("FAIL random cycle %0d: got m=%h/%b/%b/%b l=%h/%b/%b/%b want m=%h/%b/%b/%b l=%h/%b/%b/%b", c,
                 wo_m, wv_m, ov_m, pe_m, wo_l, wv_l, ov_l, pe_l,
                 e_word[0], e_valid[0], e_ovf[0], e_perr[0], e_word[1], e_valid[1], e_ovf[1], e_perr[1]);
      end
    end
    rst_n = 1'b1; bit_valid = 1'b0;
  endtask
  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first_gaps();
    test_overflow();
    test_reset_mid_frame();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
